// File: rtl/rtdc_pkg.sv
// Shared constants for the RTC display path: digit indices and the BCD-to-7-segment table.
package rtdc_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [2:0] DIG_SEC_L = 3'd0;
  localparam logic [2:0] DIG_SEC_M = 3'd1;
  localparam logic [2:0] DIG_MIN_L = 3'd2;
  localparam logic [2:0] DIG_MIN_M = 3'd3;
  localparam logic [2:0] DIG_HRL   = 3'd4;
  localparam logic [2:0] DIG_HRM   = 3'd5;

  localparam logic [6:0] SEG_DASH = 7'h40;

  // Active-high segment patterns, bit0=a .. bit6=g; element 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/rtdc_seg7_scan_bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment pattern; codes 10..15 show a dash.
module bcd_to_seg7
  import rtdc_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = seg_lookup(bcd);

endmodule

// File: rtl/rtdc_seg7_scan.sv
// Six-digit multiplexed 7-segment scanner with a per-frame snapshot of the BCD time digits.
module rtdc_seg7_scan
  import rtdc_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter bit ACTIVE_LOW_SEG  = 1'b1,
  parameter bit ACTIVE_LOW_AN   = 1'b1,
  parameter bit BLANK_LEAD_ZERO = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [3:0] SEC_L,
  input  logic [3:0] SEC_M,
  input  logic [3:0] MIN_L,
  input  logic [3:0] MIN_M,
  input  logic [3:0] HRL,
  input  logic [3:0] HRM,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [5:0] AN,
  output logic       FRAME_DONE
);

  localparam int             CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [6:0]     SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic           DP_OFF  = ACTIVE_LOW_SEG;
  localparam logic [5:0]     AN_OFF  = ACTIVE_LOW_AN ? 6'h3F : 6'h00;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [3:0]    snap [NUM_DIGITS];
  logic          primed;

  logic       tick;
  logic       wrap;
  logic [3:0] cur_digit;
  logic [6:0] dec_seg;
  logic [6:0] seg_ah;
  logic       dp_ah;
  logic [5:0] an_ah;

  assign tick = EN && (cnt == CNT_MAX);
  assign wrap = tick && (idx == DIG_HRM);

  always_comb begin
    cur_digit = snap[0];
    case (idx)
      DIG_SEC_M: cur_digit = snap[1];
      DIG_MIN_L: cur_digit = snap[2];
      DIG_MIN_M: cur_digit = snap[3];
      DIG_HRL:   cur_digit = snap[4];
      DIG_HRM:   cur_digit = snap[5];
      default:   cur_digit = snap[0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Separators sit after the hours-units and minutes-units digits (HH.MM.SS).
  always_comb begin
    seg_ah = dec_seg;
    dp_ah  = (idx == DIG_MIN_L) || (idx == DIG_HRL);
    an_ah  = 6'b000001 << idx;
    if (BLANK_LEAD_ZERO && (idx == DIG_HRM) && (cur_digit == 4'd0)) begin
      seg_ah = 7'h00;
      dp_ah  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= '0;
      idx        <= DIG_SEC_L;
      primed     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= 4'd0;
      SEG        <= SEG_OFF;
      DP         <= DP_OFF;
      AN         <= AN_OFF;
      FRAME_DONE <= 1'b0;
    end else if (EN) begin
      if (tick) begin
        cnt <= '0;
        idx <= (idx == DIG_HRM) ? DIG_SEC_L : idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      // Snapshot only at frame boundaries so a rollover never tears the shown time.
      if (!primed || wrap) begin
        snap[DIG_SEC_L] <= SEC_L;
        snap[DIG_SEC_M] <= SEC_M;
        snap[DIG_MIN_L] <= MIN_L;
        snap[DIG_MIN_M] <= MIN_M;
        snap[DIG_HRL]   <= HRL;
        snap[DIG_HRM]   <= HRM;
        primed          <= 1'b1;
      end
      SEG        <= seg_ah ^ {7{ACTIVE_LOW_SEG}};
      DP         <= dp_ah ^ ACTIVE_LOW_SEG;
      AN         <= an_ah ^ {6{ACTIVE_LOW_AN}};
      FRAME_DONE <= wrap;
    end else begin
      SEG        <= SEG_OFF;
      DP         <= DP_OFF;
      AN         <= AN_OFF;
      FRAME_DONE <= 1'b0;
    end
  end

endmodule

// File: doc/rtdc_seg7_scan.md
Name: rtdc_seg7_scan

Overview:
Display-side consumer of the real-time clock's six BCD time digits (HH:MM:SS). It snapshots the digits once per scan frame so the display never shows a torn time across a rollover. It time-multiplexes the digits onto a shared 7-segment bus with one anode per digit. It sits between the clock counter and the board's 6-digit common-anode display.

Parameters:
SCAN_DIV, 1000, CLK cycles each digit is driven (>=2)
ACTIVE_LOW_SEG, 1, 1 = SEG/DP driven low to light
ACTIVE_LOW_AN, 1, 1 = AN driven low to select digit
BLANK_LEAD_ZERO, 1, 1 = blank hour-tens digit when it is 0

Ports:
CLK  input  1  clock
RST  input  1  synchronous, active-high reset
EN  input  1  display enable; low = display dark, scan frozen
SEC_L  input  4  BCD seconds units
SEC_M  input  4  BCD seconds tens
MIN_L  input  4  BCD minutes units
MIN_M  input  4  BCD minutes tens
HRL  input  4  BCD hours units
HRM  input  4  BCD hours tens
SEG  output  7  segments, bit0=a .. bit6=g
DP  output  1  decimal point
AN  output  6  digit select, bit i = digit index i
FRAME_DONE  output  1  one-cycle pulse when a full 6-digit frame completes

Behaviour:
- Reset is synchronous, active-high on RST, clock CLK. Reset values: cnt=0, idx=0, snap[0..5]=0, primed=0. SEG, DP, AN all at inactive level (all segments off, no anode selected). FRAME_DONE=0.
- Prescaler cnt counts 0..SCAN_DIV-1 while EN=1. tick = EN & (cnt==SCAN_DIV-1). On tick cnt->0 and idx advances 0,1,2,3,4,5,0 (wraps 5->0).
- Digit mapping: idx0=SEC_L, 1=SEC_M, 2=MIN_L, 3=MIN_M, 4=HRL, 5=HRM. AN bit idx is selected.
- Snapshot: all six inputs are copied into snap on the tick where idx wraps 5->0. They are also copied on the first EN=1 cycle with primed=0, which sets primed=1. The display uses snap only, never the live inputs.
- FRAME_DONE=1 for exactly the cycle after the 5->0 tick. Its latency matches the outputs.
- Outputs are registered. SEG/DP/AN on cycle n+1 reflect idx/snap at cycle n, giving 1-cycle latency.
- Decode (active-high form, before polarity applied): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Any value 10..15 decodes to 40 (dash, segment g only).
- DP is lit on idx 2 and idx 4 (separators HH.MM.SS). It is off on all other digits.
- Leading-zero blanking: if BLANK_LEAD_ZERO=1, idx=5 and snap value is 0, then SEG is all off and DP is off. AN is still selected.
- Polarity: when ACTIVE_LOW_SEG=1, SEG and DP are inverted. When ACTIVE_LOW_AN=1, AN is inverted (e.g. idx0 -> 6'b111110).
- EN=0: cnt, idx and snap hold. On the next cycle SEG/DP/AN go inactive and FRAME_DONE=0. When EN returns to 1, scanning resumes from the held idx/cnt and no snapshot is taken (primed is already 1).
- RST asserted mid-frame: all state returns to reset values on that edge and the display goes dark the next cycle. Priority order: RST > EN.
- Input changes between snapshots have no visible effect until the next frame boundary.

Decomposition:
- Shared package rtdc_pkg holds:
  - digit index constants (DIG_SEC_L=0 .. DIG_HRM=5)
  - NUM_DIGITS=6
  - the 16-entry BCD-to-segment constant table, including the dash code 7'h40
- One natural sub-module: bcd_to_seg7. It is purely combinational, 4-bit in, 7-bit active-high out, with dash for invalid codes. The scanner instantiates it once on the muxed snap digit.

Test Plan:
- Reset / polarity: RST=1 for 3 cycles, defaults, SCAN_DIV=4. Expect SEG=7'h7F, DP=1, AN=6'h3F, FRAME_DONE=0 during reset and on the cycle after release.
- Basic scan: EN=1, inputs 23:59:58 (HRM=2,HRL=3,MIN_M=5,MIN_L=9,SEC_M=5,SEC_L=8), SCAN_DIV=4.
  - AN walks 3E,3D,3B,37,2F,1F, each held 4 cycles.
  - SEG (inverted) = 00,12,10,12,30,24.
  - DP=0 only on AN=3B and 2F.
  - FRAME_DONE pulses once every 24 cycles.
- Tear-free snapshot: change inputs to 00:00:00 while idx=2. Displayed digits for idx 3..5 still show 5,3,2. The new values appear only after FRAME_DONE.
- Blanking and invalid digit: HRM=0 -> at idx5 SEG=7'h7F with AN=1F. SEC_L=4'hC -> at idx0 SEG=7'h3F (dash).
- EN gating: drop EN for 10 cycles mid-digit at idx3 with cnt=1.
  - Outputs go inactive the next cycle.
  - On re-enable, idx3 resumes and is held 3 more cycles.
  - No extra FRAME_DONE is produced.
- Reset mid-frame: assert RST at idx4. The next cycle is dark. After release the first frame starts at idx0 with a fresh snapshot of the current inputs.
